seg_scan_display: RTL and testbench

- Parametrised multiplexed seven-segment display controller, the successor to the fixed 4-digit scanner used on the CPU test board.
- Takes a packed hex value from the memory-mapped display register write path and drives DIGITS common-anode digits in time-multiplexed fashion.
- Adds per-digit decimal points, tear-free frame-synchronous updates, an enable/blank control and a frame-boundary pulse.
- Sits between the RAM I/O decode (display address write strobe) and the board's dig/seg pins.

---
 rtl/seg_scan_display.sv | 155 +++++++++++++++
 tb/tb_seg_scan_display.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed seven-segment scanner. Writes land in a shadow register that is copied to the display on each frame wrap.
// Optional build macro SEG_SCAN_DEADTIME_EN blanks the first DEADTIME cycles of every digit slot.
module seg_scan_display #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter int DEADTIME       = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  output logic [DIGITS-1:0]     dig,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_display: DIGITS must be 1..8");
  end
  if (CLK_DIV < 2 || CLK_DIV > (1 << 20)) begin : g_bad_div
    $error("seg_scan_display: CLK_DIV must be 2..2^20");
  end
  if (DEADTIME >= CLK_DIV) begin : g_bad_deadtime
    $error("seg_scan_display: DEADTIME must be less than CLK_DIV");
  end

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] display;
  logic [DIGITS-1:0]   dp_shadow;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   dig_on;
  logic [7:0]          seg_on;
  logic                slot_end;
  logic                frame_wrap;
  logic                blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;

  assign slot_end   = enable && (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // NOTE: every register below uses non-blocking assignment so all of them
  // sample the pre-edge values; display <= shadow on a colliding write relies on it.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (wr_en) begin
      shadow    <= wr_data;
      dp_shadow <= wr_dp;
    end
  end

  // Prescaler and digit index; disabling parks both at zero so a restart begins at digit 0.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: display/dp are small flop banks, not RAM, so they take the async
  // reset and the screen is defined as all zeros until the first frame load.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      display    <= '0;
      dp         <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        display <= shadow;
        dp      <= dp_shadow;
      end
    end
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = display[4*i +: 4];
        cur_dp  = dp[i];
      end
    end
  end

`ifdef SEG_SCAN_DEADTIME_EN
  assign blank = (cnt < CNT_W'(DEADTIME));
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Pin drivers are registered in active-high form; polarity is folded in at the port.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dig_on <= '0;
      seg_on <= '0;
    end else if (!enable || blank) begin
      dig_on <= '0;
      seg_on <= '0;
    end else begin
      dig_on <= DIGITS'(1) << idx;
      seg_on <= {cur_dp, seg_decode(cur_nib)};
    end
  end

  assign dig = dig_on ^ {DIGITS{DIG_ACTIVE_LOW}};
  assign seg = seg_on ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=4, CLK_DIV=4, active-low pins.
// Expectations follow SEG_SCAN_DEADTIME_EN when the bench is built with it (DEADTIME=1).
module tb_seg_scan_display;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 4;
  localparam int DEADTIME = 1;
`ifdef SEG_SCAN_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic        enable;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  seg_scan_display #(
    .DIGITS(DIGITS),
    .CLK_DIV(CLK_DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1),
    .DEADTIME(DEADTIME)
  ) dut (
    .clk(clk),
    .res(res),
    .enable(enable),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_dp(wr_dp),
    .dig(dig),
    .seg(seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic bit blank_at(input int pos);
    return DT_EN && (pos < DEADTIME);
  endfunction

  function automatic logic [3:0] dig_exp(input int d, input int pos);
    logic [3:0] one;
    one = 4'b0001 << d;
    return blank_at(pos) ? 4'hF : ~one;
  endfunction

  function automatic logic [7:0] seg_exp(input logic [7:0] lit, input int pos);
    return blank_at(pos) ? 8'hFF : lit;
  endfunction

  // Runs one 16-clk frame from a frame boundary; s0..s3 are the active-low seg values per digit.
  task automatic expect_frame(input string name, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input int wr_at,
                              input logic [15:0] d, input logic [3:0] p);
    logic [7:0] lit;
    logic [3:0] ed;
    logic [7:0] es;
    logic       et;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (e == wr_at) begin
        wr_en   = 1'b1;
        wr_data = d;
        wr_dp   = p;
      end
      case (e / 4)
        0:       lit = s0;
        1:       lit = s1;
        2:       lit = s2;
        default: lit = s3;
      endcase
      ed = dig_exp(e / 4, e % 4);
      es = seg_exp(lit, e % 4);
      et = (e == 15);
      checks++;
      if (dig !== ed) begin
        errors++;
        $display("FAIL %s dig e=%0d: got %h want %h", name, e, dig, ed);
      end
      checks++;
      if (seg !== es) begin
        errors++;
        $display("FAIL %s seg e=%0d: got %h want %h", name, e, seg, es);
      end
      checks++;
      if (frame_tick !== et) begin
        errors++;
        $display("FAIL %s frame_tick e=%0d: got %b want %b", name, e, frame_tick, et);
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) #1;
      else begin
        repeat (2) @(posedge clk);
        #1;
      end
      checks++;
      if (dig !== 4'hF) begin errors++; $display("FAIL reset dig: got %h want F", dig); end
      checks++;
      if (seg !== 8'hFF) begin errors++; $display("FAIL reset seg: got %h want FF", seg); end
      checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset frame_tick: got %b want 0", frame_tick); end
    end
    res = 1'b0;
  endtask

  task automatic test_frame_update();
    expect_frame("boot", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 16'h1A2F, 4'b0000);
    expect_frame("update", 8'h8E, 8'hA4, 8'h88, 8'hF9, -1, 16'h0, 4'h0);
  endtask

  task automatic test_write_collision();
    expect_frame("collide", 8'h8E, 8'hA4, 8'h88, 8'hF9, 14, 16'h0005, 4'b0000);
    expect_frame("old_held", 8'h8E, 8'hA4, 8'h88, 8'hF9, -1, 16'h0, 4'h0);
    expect_frame("new_val", 8'h92, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_decimal_point();
    expect_frame("dp_write", 8'h92, 8'hC0, 8'hC0, 8'hC0, 3, 16'h0000, 4'b0010);
    expect_frame("dp_shown", 8'hC0, 8'h40, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_enable();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dig !== 4'hB) begin errors++; $display("FAIL en_pre dig: got %h want B", dig); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL en_pre seg: got %h want C0", seg); end
    enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      wr_en = (n == 0);
      wr_data = 16'h0030;
      wr_dp   = 4'b0000;
      checks++;
      if (dig !== 4'hF) begin errors++; $display("FAIL en_off dig n=%0d: got %h want F", n, dig); end
      checks++;
      if (seg !== 8'hFF) begin errors++; $display("FAIL en_off seg n=%0d: got %h want FF", n, seg); end
      checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL en_off frame_tick n=%0d: got %b want 0", n, frame_tick); end
    end
    wr_en  = 1'b0;
    enable = 1'b1;
    expect_frame("reenable", 8'hC0, 8'h40, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
    expect_frame("reen_update", 8'hC0, 8'hB0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_reset_midscan();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dig !== 4'hE) begin errors++; $display("FAIL mid_pre dig: got %h want E", dig); end
    res = 1'b1;
    #1;
    checks++;
    if (dig !== 4'hF) begin errors++; $display("FAIL mid_async dig: got %h want F", dig); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL mid_async seg: got %h want FF", seg); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_async frame_tick: got %b want 0", frame_tick); end
    @(posedge clk); #1;
    res = 1'b0;
    expect_frame("post_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
    expect_frame("post_reset2", 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_frame_update();
    test_write_collision();
    test_decimal_point();
    test_enable();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
